// File: rtl/mmio_display_ctrl_pkg.sv
// mmio_display_pkg: shared address map, segment width and CTRL field layout
package mmio_display_pkg;
  localparam int SEG_W = 7;
  localparam int MAX_DIGITS = 8;
  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_BLANK_LSB = 8;
  localparam int CTRL_BLANK_W = 8;
  typedef enum logic [3:0] {
    ADDR_DISP_LO = 4'h0,
    ADDR_DISP_HI = 4'h1,
    ADDR_CTRL    = 4'h2,
    ADDR_SW      = 4'h4,
    ADDR_SW_CHG  = 4'h5
  } io_addr_e;
endpackage

// File: rtl/mmio_display_ctrl_if.sv
// mmio_display_ctrl_if: MIPS IO bus (word address, write strobe/data, combinational read data)
interface mmio_display_ctrl_if;
  logic [3:0]  IOAddr;
  logic        IOWriteEn;
  logic [31:0] IOWriteData;
  logic [31:0] IOReadData;
  modport master (output IOAddr, IOWriteEn, IOWriteData, input IOReadData);
  modport slave  (input IOAddr, IOWriteEn, IOWriteData, output IOReadData);
endinterface

// File: rtl/mmio_display_ctrl_debouncer.sv
// switch_debouncer: two-flop synchroniser plus counter debouncer for a switch vector
//   CLK, RESET   clock, async active-high reset
//   i_sw         raw asynchronous switches
//   o_deb        debounced value
//   o_changed    bits that flip on this cycle's debounced update (zero otherwise)
module switch_debouncer #(
  parameter int SW_W = 2,
  parameter int DEB_CYC = 50000
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [SW_W-1:0] i_sw,
  output logic [SW_W-1:0] o_deb,
  output logic [SW_W-1:0] o_changed
);
  localparam int CW = $clog2(DEB_CYC + 1);
  logic [SW_W-1:0] r_s1, r_s2, r_deb;
  logic [CW-1:0] r_cnt;
  logic w_diff, w_fire;
  assign w_diff = r_s2 != r_deb;
  // the counter only tracks "differs from debounced", so any run of DEB_CYC differing cycles commits
  assign w_fire = w_diff && r_cnt == CW'(DEB_CYC - 1);
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_deb <= '0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_sw;
      r_s2 <= r_s1;
      r_cnt <= (w_diff && !w_fire) ? r_cnt + CW'(1) : '0;
      if (w_fire) r_deb <= r_s2;
    end
  assign o_deb = r_deb;
  assign o_changed = w_fire ? r_s2 ^ r_deb : '0;
endmodule

// File: rtl/mmio_display_ctrl.sv
// mmio_display_ctrl: MMIO peripheral driving a multiplexed 7-segment display and debounced switches
//   CLK, RESET   clock, async active-high reset
//   bus          IO bus slave: DISP_LO/DISP_HI/CTRL (R/W), SW (RO), SW_CHG (W1C)
//   SWITCHES     raw switch inputs
//   LED, AN      active-low segments and digit anodes, registered
module mmio_display_ctrl
  import mmio_display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int REFRESH_BITS = 16,
  parameter int SW_W = 2,
  parameter int DEB_CYC = 50000
) (
  input  logic                  CLK,
  input  logic                  RESET,
  mmio_display_ctrl_if.slave    bus,
  input  logic [SW_W-1:0]       SWITCHES,
  output logic [SEG_W-1:0]      LED,
  output logic [NUM_DIGITS-1:0] AN
);
  localparam int DW = SEG_W * MAX_DIGITS;
  localparam int HALF = DW / 2;
  // fields of absent digits are masked off at write time so they always read 0
  localparam logic [63:0] W_MASK64 = (64'd1 << (SEG_W * NUM_DIGITS)) - 64'd1;
  localparam logic [DW-1:0] DMASK = W_MASK64[DW-1:0];
  logic [DW-1:0] r_disp;
  logic r_en;
  logic [CTRL_BLANK_W-1:0] r_blank;
  logic [SW_W-1:0] r_chg;
  logic [REFRESH_BITS-1:0] r_ref;
  logic [2:0] r_idx;
  logic [NUM_DIGITS-1:0] r_an;
  logic [SEG_W-1:0] r_led;
  logic [SW_W-1:0] w_deb, w_changed;
  logic w_wr_lo, w_wr_hi, w_wr_ctrl, w_wr_chg, w_dark;
  logic [SEG_W-1:0] w_seg;
  logic [NUM_DIGITS-1:0] w_an;
  switch_debouncer #(.SW_W(SW_W), .DEB_CYC(DEB_CYC)) u_deb (
    .CLK(CLK), .RESET(RESET), .i_sw(SWITCHES), .o_deb(w_deb), .o_changed(w_changed)
  );
  assign w_wr_lo = bus.IOWriteEn && bus.IOAddr == ADDR_DISP_LO;
  assign w_wr_hi = bus.IOWriteEn && bus.IOAddr == ADDR_DISP_HI;
  assign w_wr_ctrl = bus.IOWriteEn && bus.IOAddr == ADDR_CTRL;
  assign w_wr_chg = bus.IOWriteEn && bus.IOAddr == ADDR_SW_CHG;
  assign w_dark = !r_en || r_blank[r_idx];
  assign w_seg = r_disp[r_idx*SEG_W +: SEG_W];
  assign w_an = ~(NUM_DIGITS'(1) << r_idx);
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      r_disp <= '0;
      r_en <= 1'b1;
      r_blank <= '0;
      r_chg <= '0;
      r_ref <= '0;
      r_idx <= '0;
      r_an <= '1;
      r_led <= '1;
    end else begin
      if (w_wr_lo) r_disp[HALF-1:0] <= bus.IOWriteData[HALF-1:0] & DMASK[HALF-1:0];
      if (w_wr_hi) r_disp[DW-1:HALF] <= bus.IOWriteData[HALF-1:0] & DMASK[DW-1:HALF];
      if (w_wr_ctrl) begin
        r_en <= bus.IOWriteData[CTRL_EN_BIT];
        r_blank <= bus.IOWriteData[CTRL_BLANK_LSB +: CTRL_BLANK_W];
      end
      // clear first, then OR in new changes so a simultaneous set wins
      r_chg <= (r_chg & ~(w_wr_chg ? bus.IOWriteData[SW_W-1:0] : '0)) | w_changed;
      r_ref <= r_ref + 1'b1;
      if (&r_ref) r_idx <= (r_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : r_idx + 3'd1;
      r_an <= w_dark ? '1 : w_an;
      r_led <= w_dark ? '1 : ~w_seg;
    end
  assign LED = r_led;
  assign AN = r_an;
  assign bus.IOReadData = bus.IOAddr == ADDR_DISP_LO ? {4'b0, r_disp[HALF-1:0]} :
                          bus.IOAddr == ADDR_DISP_HI ? {4'b0, r_disp[DW-1:HALF]} :
                          bus.IOAddr == ADDR_CTRL    ? {16'b0, r_blank, 7'b0, r_en} :
                          bus.IOAddr == ADDR_SW      ? 32'(w_deb) :
                          bus.IOAddr == ADDR_SW_CHG  ? 32'(r_chg) : 32'd0;
endmodule

// File: tb/tb_mmio_display_ctrl.sv
// tb_mmio_display_ctrl: randomized self-checking bench for 4-digit and 6-digit display controllers
module tb_mmio_display_ctrl;
  import mmio_display_pkg::*;
  localparam int DEB = 4;
  localparam int RB = 3;
  localparam int PER = 1 << RB;
  logic CLK = 0;
  logic RESET = 1;
  logic [1:0] SWITCHES = 0;
  logic [6:0] LED4, LED6;
  logic [3:0] AN4;
  logic [5:0] AN6;
  mmio_display_ctrl_if bus4();
  mmio_display_ctrl_if bus6();
  mmio_display_ctrl #(.NUM_DIGITS(4), .REFRESH_BITS(RB), .SW_W(2), .DEB_CYC(DEB)) dut4 (
    .CLK(CLK), .RESET(RESET), .bus(bus4), .SWITCHES(SWITCHES), .LED(LED4), .AN(AN4)
  );
  mmio_display_ctrl #(.NUM_DIGITS(6), .REFRESH_BITS(RB), .SW_W(2), .DEB_CYC(DEB)) dut6 (
    .CLK(CLK), .RESET(RESET), .bus(bus6), .SWITCHES(SWITCHES), .LED(LED6), .AN(AN6)
  );
  always #5 CLK = ~CLK;
  int cyc;
  always @(posedge CLK or posedge RESET) cyc <= RESET ? 0 : cyc + 1;
  int pass_cnt = 0;
  int chk_cnt = 0;
  logic [6:0] m_dig [2][8];
  logic m_en [2];
  logic [7:0] m_blank [2];
  logic [1:0] m_sw;
  logic [1:0] m_flags [2];
  int ndig [2] = '{4, 6};

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int d = 0; d < 8; d++) m_dig[k][d] = 0;
      m_en[k] = 1;
      m_blank[k] = 0;
      m_flags[k] = 0;
    end
    m_sw = 0;
  endfunction

  function automatic void model_write(int k, logic [3:0] a, logic [31:0] d);
    if (a == 4'h0 || a == 4'h1)
      for (int i = 0; i < 4; i++) begin
        int g = i + (a == 4'h1 ? 4 : 0);
        if (g < ndig[k]) m_dig[k][g] = d[7*i +: 7];
      end
    else if (a == 4'h2) begin
      m_en[k] = d[0];
      m_blank[k] = d[15:8];
    end else if (a == 4'h5) m_flags[k] = m_flags[k] & ~d[1:0];
  endfunction

  function automatic logic [31:0] exp_rd(int k, logic [3:0] a);
    logic [31:0] v = 0;
    if (a == 4'h0 || a == 4'h1)
      for (int i = 0; i < 4; i++) v[7*i +: 7] = m_dig[k][i + (a == 4'h1 ? 4 : 0)];
    else if (a == 4'h2) v = {16'b0, m_blank[k], 7'b0, m_en[k]};
    else if (a == 4'h4) v = 32'(m_sw);
    else if (a == 4'h5) v = 32'(m_flags[k]);
    return v;
  endfunction

  function automatic bit dark(int k, int idx);
    return !m_en[k] || m_blank[k][idx];
  endfunction

  function automatic logic [7:0] exp_an(int k, int idx);
    int mask = (1 << ndig[k]) - 1;
    return dark(k, idx) ? 8'(mask) : 8'(~(1 << idx) & mask);
  endfunction

  function automatic logic [6:0] exp_led(int k, int idx);
    return dark(k, idx) ? 7'h7F : ~m_dig[k][idx];
  endfunction

  task automatic wr(input int k, input logic [3:0] a, input logic [31:0] d);
    @(negedge CLK);
    if (k == 0) begin bus4.IOAddr = a; bus4.IOWriteEn = 1; bus4.IOWriteData = d; end
    else begin bus6.IOAddr = a; bus6.IOWriteEn = 1; bus6.IOWriteData = d; end
    @(negedge CLK);
    bus4.IOWriteEn = 0;
    bus6.IOWriteEn = 0;
    model_write(k, a, d);
  endtask

  task automatic rd(input int k, input logic [3:0] a, output logic [31:0] d);
    if (k == 0) bus4.IOAddr = a; else bus6.IOAddr = a;
    #1;
    d = (k == 0) ? bus4.IOReadData : bus6.IOReadData;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    repeat (3) @(negedge CLK);
    chk_cnt++;
    if (AN4 !== 4'hF || AN6 !== 6'h3F || LED4 !== 7'h7F)
      $display("FAIL reset_hold got AN4=%h AN6=%h LED4=%h exp AN4=f AN6=3f LED4=7f", AN4, AN6, LED4);
    else pass_cnt++;
    RESET = 0;
    @(negedge CLK);
    chk_cnt++;
    if (AN4 !== 4'b1110 || LED4 !== 7'h7F)
      $display("FAIL reset_first_digit got AN4=%b LED4=%h exp AN4=1110 LED4=7f", AN4, LED4);
    else pass_cnt++;
    for (int a = 0; a < 16; a++)
      for (int k = 0; k < 2; k++) begin
        rd(k, 4'(a), v);
        chk_cnt++;
        if (v !== (a == 2 ? 32'h1 : 32'h0))
          $display("FAIL reset_read dut=%0d addr=%h got=%h exp=%h", k, a, v, (a == 2 ? 32'h1 : 32'h0));
        else pass_cnt++;
        if (k == 1) @(negedge CLK);
      end
  endtask

  task automatic test_refresh();
    logic [31:0] v;
    wr(0, ADDR_DISP_LO, 32'h0204081);
    rd(0, ADDR_DISP_LO, v);
    chk_cnt++;
    if (v !== 32'h0204081) $display("FAIL disp_lo_readback got=%h exp=%h", v, 32'h0204081);
    else pass_cnt++;
    wr(1, ADDR_DISP_HI, 32'hFFFFFFFF);
    rd(1, ADDR_DISP_HI, v);
    chk_cnt++;
    if (v !== 32'h3FFF) $display("FAIL disp_hi_mask got=%h exp=%h", v, 32'h3FFF);
    else pass_cnt++;
    wr(1, ADDR_DISP_HI, 32'h3FFF);
    wr(1, ADDR_DISP_LO, $urandom);
    rd(1, ADDR_DISP_LO, v);
    chk_cnt++;
    if (v !== exp_rd(1, ADDR_DISP_LO)) $display("FAIL disp_lo6_readback got=%h exp=%h", v, exp_rd(1, ADDR_DISP_LO));
    else pass_cnt++;
    for (int c = 0; c < 2 * 6 * PER + 2; c++) begin
      int i4, i6;
      @(negedge CLK);
      i4 = ((cyc - 1) / PER) % 4;
      i6 = ((cyc - 1) / PER) % 6;
      chk_cnt++;
      if ({4'b0, AN4} !== exp_an(0, i4) || LED4 !== exp_led(0, i4))
        $display("FAIL refresh4 cyc=%0d got AN=%b LED=%h exp AN=%b LED=%h", cyc, AN4, LED4, exp_an(0, i4), exp_led(0, i4));
      else pass_cnt++;
      chk_cnt++;
      if ({2'b0, AN6} !== exp_an(1, i6) || LED6 !== exp_led(1, i6))
        $display("FAIL refresh6 cyc=%0d got AN=%b LED=%h exp AN=%b LED=%h", cyc, AN6, LED6, exp_an(1, i6), exp_led(1, i6));
      else pass_cnt++;
    end
  endtask

  task automatic test_blank();
    logic [31:0] v;
    wr(0, ADDR_CTRL, 32'h0501);
    rd(0, ADDR_CTRL, v);
    chk_cnt++;
    if (v !== 32'h0501) $display("FAIL ctrl_readback got=%h exp=%h", v, 32'h0501);
    else pass_cnt++;
    for (int pass = 0; pass < 2; pass++) begin
      for (int c = 0; c < 4 * PER; c++) begin
        int i4;
        @(negedge CLK);
        i4 = ((cyc - 1) / PER) % 4;
        chk_cnt++;
        if ({4'b0, AN4} !== exp_an(0, i4) || LED4 !== exp_led(0, i4))
          $display("FAIL blank pass=%0d cyc=%0d got AN=%b LED=%h exp AN=%b LED=%h", pass, cyc, AN4, LED4, exp_an(0, i4), exp_led(0, i4));
        else pass_cnt++;
      end
      wr(0, ADDR_CTRL, 32'h0);
    end
    wr(0, ADDR_CTRL, 32'h1);
  endtask

  task automatic test_switch();
    logic [31:0] v, f;
    for (int it = 0; it < 8; it++) begin
      logic [1:0] old = m_sw;
      if (it % 2 == 1) begin
        logic [1:0] g = (it == 1) ? 2'b11 : old ^ 2'($urandom_range(1, 3));
        int len = (it == 1) ? 3 : $urandom_range(1, DEB - 1);
        @(negedge CLK);
        SWITCHES = g;
        for (int c = 0; c < len; c++) @(negedge CLK);
        SWITCHES = old;
        for (int c = 0; c < DEB + 4; c++) begin
          @(negedge CLK);
          rd(0, ADDR_SW, v);
          chk_cnt++;
          if (v !== 32'(old)) $display("FAIL glitch it=%0d len=%0d got=%h exp=%h", it, len, v, 32'(old));
          else pass_cnt++;
        end
      end else begin
        logic [1:0] nv = (it == 0) ? 2'b01 : old ^ 2'($urandom_range(1, 3));
        @(negedge CLK);
        SWITCHES = nv;
        for (int c = 1; c <= DEB + 4; c++) begin
          @(negedge CLK);
          if (c == 2 + DEB) begin
            m_sw = nv;
            m_flags[0] = m_flags[0] | (old ^ nv);
            m_flags[1] = m_flags[1] | (old ^ nv);
          end
          rd(0, ADDR_SW, v);
          chk_cnt++;
          if (v !== 32'(m_sw)) $display("FAIL sw_latency it=%0d c=%0d got=%h exp=%h", it, c, v, 32'(m_sw));
          else pass_cnt++;
          if (c == 2 + DEB) begin
            rd(0, ADDR_SW_CHG, f);
            chk_cnt++;
            if (f !== 32'(m_flags[0])) $display("FAIL sw_chg4 it=%0d got=%h exp=%h", it, f, 32'(m_flags[0]));
            else pass_cnt++;
            rd(1, ADDR_SW_CHG, f);
            chk_cnt++;
            if (f !== 32'(m_flags[1])) $display("FAIL sw_chg6 it=%0d got=%h exp=%h", it, f, 32'(m_flags[1]));
            else pass_cnt++;
          end
        end
      end
    end
  endtask

  task automatic test_w1c_collision();
    logic [31:0] v;
    wr(0, ADDR_SW_CHG, 32'hFFFF);
    rd(0, ADDR_SW_CHG, v);
    chk_cnt++;
    if (v !== 32'h0) $display("FAIL w1c_clear got=%h exp=0", v);
    else pass_cnt++;
    SWITCHES = m_sw ^ 2'b01;
    repeat (4) @(negedge CLK);
    wr(0, ADDR_SW_CHG, 32'h1);
    m_flags[0] = m_flags[0] | 2'b01;
    m_flags[1] = m_flags[1] | 2'b01;
    m_sw = m_sw ^ 2'b01;
    rd(0, ADDR_SW_CHG, v);
    chk_cnt++;
    if (v !== 32'(m_flags[0])) $display("FAIL w1c_set_wins got=%h exp=%h", v, 32'(m_flags[0]));
    else pass_cnt++;
    rd(0, ADDR_SW, v);
    chk_cnt++;
    if (v !== 32'(m_sw)) $display("FAIL w1c_sw got=%h exp=%h", v, 32'(m_sw));
    else pass_cnt++;
    repeat (3) @(negedge CLK);
    wr(0, ADDR_SW_CHG, 32'h1);
    rd(0, ADDR_SW_CHG, v);
    chk_cnt++;
    if (v !== 32'(m_flags[0])) $display("FAIL w1c_later got=%h exp=%h", v, 32'(m_flags[0]));
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] v;
    for (int n = 0; n < 40; n++) begin
      int k = $urandom_range(0, 1);
      logic [3:0] a = 4'($urandom_range(0, 15));
      wr(k, a, $urandom);
      rd(k, a, v);
      chk_cnt++;
      if (v !== exp_rd(k, a)) $display("FAIL random_rw dut=%0d addr=%h got=%h exp=%h", k, a, v, exp_rd(k, a));
      else pass_cnt++;
    end
    for (int a = 0; a < 16; a++) begin
      @(negedge CLK);
      for (int k = 0; k < 2; k++) begin
        rd(k, 4'(a), v);
        chk_cnt++;
        if (v !== exp_rd(k, 4'(a))) $display("FAIL random_sweep dut=%0d addr=%h got=%h exp=%h", k, a, v, exp_rd(k, 4'(a)));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    wr(0, ADDR_CTRL, 32'h1);
    wr(0, ADDR_DISP_LO, 32'h0FFFFFFF);
    SWITCHES = m_sw ^ 2'b10;
    repeat (3) @(negedge CLK);
    @(posedge CLK);
    #2 RESET = 1;
    #1;
    chk_cnt++;
    if (AN4 !== 4'hF || LED4 !== 7'h7F || AN6 !== 6'h3F)
      $display("FAIL async_reset got AN4=%h LED4=%h AN6=%h exp f 7f 3f", AN4, LED4, AN6);
    else pass_cnt++;
    model_reset();
    SWITCHES = 0;
    @(negedge CLK);
    RESET = 0;
    for (int c = 0; c < DEB + 4; c++) begin
      @(negedge CLK);
      rd(0, ADDR_SW, v);
      chk_cnt++;
      if (v !== 32'h0) $display("FAIL reset_sw c=%0d got=%h exp=0", c, v);
      else pass_cnt++;
    end
    for (int a = 0; a < 6; a++) begin
      rd(0, 4'(a), v);
      chk_cnt++;
      if (v !== exp_rd(0, 4'(a))) $display("FAIL reset_regs addr=%h got=%h exp=%h", a, v, exp_rd(0, 4'(a)));
      else pass_cnt++;
      @(negedge CLK);
    end
  endtask

  initial begin
    bus4.IOAddr = 0; bus4.IOWriteEn = 0; bus4.IOWriteData = 0;
    bus6.IOAddr = 0; bus6.IOWriteEn = 0; bus6.IOWriteData = 0;
    model_reset();
    test_reset();
    test_refresh();
    test_blank();
    test_switch();
    test_w1c_collision();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
